// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit; define CU_ILLEGAL_TRAP_EN to halt on undefined opcodes
module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        stop,
  output logic        Pout,
  output logic        Pen,
  output logic        IncPC,
  output logic        MARen,
  output logic        MDRen,
  output logic        Read,
  output logic        Write,
  output logic        MDROut,
  output logic        IRen,
  output logic        Yen,
  output logic        ZLOen,
  output logic        ZLOout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        BAout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  alu_control,
  output logic        run,
  output logic        illegal_op
);
  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALTED} state_t;
  state_t state, nxt, fin, bad_next;
  logic [4:0] opcode;
  logic is_ld, is_st, is_alu, is_addi, is_mfhi, is_mflo, is_nop, is_halt;
  logic arith, mem, mf, known;
  logic unused_ir;
  assign opcode  = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign is_ld   = opcode == 5'b00000;
  assign is_st   = opcode == 5'b00010;
  assign is_alu  = opcode inside {5'b00011, 5'b00100, 5'b00101, 5'b00110};
  assign is_addi = opcode == 5'b01100;
  assign is_mfhi = opcode == 5'b11000;
  assign is_mflo = opcode == 5'b11001;
  assign is_nop  = opcode == 5'b11010;
  assign is_halt = opcode == 5'b11011;
  assign arith   = is_alu | is_addi;
  assign mem     = is_ld | is_st;
  assign mf      = is_mfhi | is_mflo;
  assign known   = arith | mem | mf | is_nop | is_halt;
  assign fin     = stop ? HALTED : T0;
  assign run     = state != RST && state != HALTED;
`ifdef CU_ILLEGAL_TRAP_EN
  assign bad_next   = HALTED;
  assign illegal_op = state == HALTED && !known;
`else
  assign bad_next   = fin;
  assign illegal_op = 1'b0;
`endif
  // state register; clr forces RST at any time
  always_ff @(posedge clk or posedge clr)
    if (clr) state <= RST;
    else     state <= nxt;
  // next state: stop is honoured only in each instruction's last step
  always_comb begin
    nxt = state;
    case (state)
      RST:    nxt = T0;
      T0:     nxt = T1;
      T1:     nxt = T2;
      T2:     nxt = is_halt ? HALTED : (arith | mem | mf) ? T3 : known ? fin : bad_next;
      T3:     nxt = mf ? fin : T4;
      T4:     nxt = T5;
      T5:     nxt = mem ? T6 : fin;
      T6:     nxt = T7;
      T7:     nxt = fin;
      HALTED: nxt = HALTED;
      default: nxt = RST;
    endcase
  end
  // control strobes per step, qualified by opcode class
  always_comb begin
    {Pout, Pen, IncPC, MARen, MDRen, Read, Write, MDROut, IRen, Yen, ZLOen} = '0;
    {ZLOout, HIout, LOout, Cout, BAout, Gra, Grb, Grc, Rin, Rout} = '0;
    alu_control = '0;
    case (state)
      T0: {Pout, MARen, IncPC, Pen} = '1;
      T1: {Read, MDRen} = '1;
      T2: {MDROut, IRen} = '1;
      T3: begin
        Grb   = arith | mem;
        Rout  = arith;
        BAout = mem;
        Yen   = arith | mem;
        HIout = is_mfhi;
        LOout = is_mflo;
        Gra   = mf;
        Rin   = mf;
      end
      T4: begin
        Grc         = is_alu;
        Rout        = is_alu;
        Cout        = is_addi | mem;
        ZLOen       = 1'b1;
        alu_control = is_alu ? opcode : 5'b00011;
      end
      T5: begin
        ZLOout = 1'b1;
        Gra    = arith;
        Rin    = arith;
        MARen  = mem;
      end
      T6: begin
        Read  = is_ld;
        MDRen = 1'b1;
        Gra   = is_st;
        Rout  = is_st;
      end
      T7: begin
        MDROut = is_ld;
        Gra    = is_ld;
        Rin    = is_ld;
        Write  = is_st;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized scoreboard bench for control_sequencer
module tb_control_sequencer;
`ifdef CU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [27:0] RUN = 28'd1 << 27, ILL = 28'd1 << 26;
  localparam logic [27:0] POUT = 28'd1 << 20, PEN = 28'd1 << 19, INCPC = 28'd1 << 18, MAREN = 28'd1 << 17;
  localparam logic [27:0] MDREN = 28'd1 << 16, READ = 28'd1 << 15, WRITE = 28'd1 << 14, MDROUT = 28'd1 << 13;
  localparam logic [27:0] IREN = 28'd1 << 12, YEN = 28'd1 << 11, ZLOEN = 28'd1 << 10, ZLOOUT = 28'd1 << 9;
  localparam logic [27:0] HIOUT = 28'd1 << 8, LOOUT = 28'd1 << 7, COUT = 28'd1 << 6, BAOUT = 28'd1 << 5;
  localparam logic [27:0] GRA = 28'd1 << 4, GRB = 28'd1 << 3, GRC = 28'd1 << 2, RIN = 28'd1 << 1, ROUT = 28'd1;
  localparam int K_NOP = 0, K_ALU = 1, K_ADDI = 2, K_MFHI = 3, K_MFLO = 4, K_LD = 5, K_ST = 6, K_HALT = 7, K_BAD = 8;

  logic clk = 1'b0, clr = 1'b1, stop = 1'b0;
  logic [31:0] ir = '0;
  logic Pout, Pen, IncPC, MARen, MDRen, Read, Write, MDROut, IRen, Yen, ZLOen;
  logic ZLOout, HIout, LOout, Cout, BAout, Gra, Grb, Grc, Rin, Rout, run, illegal_op;
  logic [4:0] alu_control;
  logic [27:0] dut_vec;
  logic [27:0] exp_q[$];
  int tag_q[$];
  int n_chk = 0, n_pass = 0, cur_tag = 0;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .stop(stop),
    .Pout(Pout), .Pen(Pen), .IncPC(IncPC), .MARen(MARen), .MDRen(MDRen), .Read(Read),
    .Write(Write), .MDROut(MDROut), .IRen(IRen), .Yen(Yen), .ZLOen(ZLOen), .ZLOout(ZLOout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .BAout(BAout), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .alu_control(alu_control), .run(run), .illegal_op(illegal_op)
  );

  assign dut_vec = {run, illegal_op, alu_control, Pout, Pen, IncPC, MARen, MDRen, Read, Write,
                    MDROut, IRen, Yen, ZLOen, ZLOout, HIout, LOout, Cout, BAout, Gra, Grb, Grc, Rin, Rout};

  always #5 clk = ~clk;

  function automatic int kind(input logic [4:0] op);
    case (op)
      5'd0: return K_LD;
      5'd2: return K_ST;
      5'd3, 5'd4, 5'd5, 5'd6: return K_ALU;
      5'd12: return K_ADDI;
      5'd24: return K_MFHI;
      5'd25: return K_MFLO;
      5'd26: return K_NOP;
      5'd27: return K_HALT;
      default: return K_BAD;
    endcase
  endfunction

  function automatic int seq_len(input logic [4:0] op);
    int c = kind(op);
    if (c == K_LD || c == K_ST) return 8;
    if (c == K_ALU || c == K_ADDI) return 6;
    if (c == K_MFHI || c == K_MFLO) return 4;
    return 3;
  endfunction

  function automatic logic [27:0] step_vec(input logic [4:0] op, input int k);
    int c = kind(op);
    logic [27:0] add3 = 28'd3 << 21;
    if (k == 0) return RUN | POUT | MARen_m() | INCPC | PEN;
    if (k == 1) return RUN | READ | MDREN;
    if (k == 2) return RUN | MDROUT | IREN;
    if (c == K_MFHI) return RUN | HIOUT | GRA | RIN;
    if (c == K_MFLO) return RUN | LOOUT | GRA | RIN;
    if (c == K_ALU || c == K_ADDI) begin
      if (k == 3) return RUN | GRB | ROUT | YEN;
      if (k == 4) return c == K_ALU ? RUN | GRC | ROUT | ZLOEN | (28'(op) << 21) : RUN | COUT | ZLOEN | add3;
      return RUN | ZLOOUT | GRA | RIN;
    end
    if (k == 3) return RUN | GRB | BAOUT | YEN;
    if (k == 4) return RUN | COUT | ZLOEN | add3;
    if (k == 5) return RUN | ZLOOUT | MAREN;
    if (k == 6) return c == K_LD ? RUN | READ | MDREN : RUN | GRA | ROUT | MDREN;
    return c == K_LD ? RUN | MDROUT | GRA | RIN : RUN | WRITE;
  endfunction

  function automatic logic [27:0] MARen_m();
    return MAREN;
  endfunction

  // scoreboard monitor: every cycle with a pending expectation is compared
  always @(negedge clk)
    if (exp_q.size() > 0) begin
      logic [27:0] e;
      int t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_chk++;
      if (dut_vec === e) n_pass++;
      else $display("FAIL step %0d (instr %0d cycle %0d): got %h expected %h", t, t / 16, t % 16, dut_vec, e);
    end

  task automatic push(input logic [27:0] v, input int k);
    exp_q.push_back(v);
    tag_q.push_back(cur_tag * 16 + k);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    stop = 1'b0;
    push('0, 14);
    @(posedge clk); #2;
    clr = 1'b0;
    push('0, 15);
    @(posedge clk); #2;
  endtask

  task automatic run_instr(input logic [31:0] iv, input int stop_k, input int clr_k);
    logic [4:0] op;
    int n;
    int c;
    op = iv[31:27];
    n = seq_len(op);
    c = kind(op);
    ir = iv;
    cur_tag++;
    for (int k = 0; k < n; k++) begin
      if (k == clr_k) begin
        do_reset();
        return;
      end
      stop = stop_k >= 0 && k >= stop_k;
      push(step_vec(op, k), k);
      @(posedge clk); #2;
    end
    if (c == K_HALT || (c == K_BAD && TRAP) || stop) begin
      for (int h = 0; h < 2; h++) begin
        push((c == K_BAD && TRAP) ? ILL : 28'd0, 10 + h);
        @(posedge clk); #2;
      end
      do_reset();
    end
  endtask

  initial begin
    logic [4:0] defs [11];
    logic [4:0] bads [5];
    defs = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd24, 5'd25, 5'd26, 5'd27};
    bads = '{5'd1, 5'd7, 5'd13, 5'd20, 5'd31};
    repeat (2) @(posedge clk);
    #2;
    push('0, 0);
    clr = 1'b0;
    @(posedge clk); #2;
    run_instr(32'h18918000, -1, -1);
    run_instr({5'b11001, 27'h0400000}, -1, -1);
    run_instr({5'b00010, 27'h1234567}, -1, -1);
    run_instr({5'b00000, 27'h0abcdef}, -1, -1);
    run_instr({5'b00000, 27'h0000010}, 3, -1);
    run_instr({5'b11011, 27'h0}, -1, -1);
    run_instr({5'b11111, 27'h0}, -1, -1);
    run_instr(32'h18918000, -1, 4);
    run_instr({5'b01100, 27'h0000042}, -1, -1);
    run_instr({5'b11010, 27'h0}, 2, -1);
    run_instr({5'b11000, 27'h0}, 3, -1);
    run_instr({5'b00110, 27'h0}, 5, 5);
    for (int i = 0; i < 150; i++) begin
      logic [4:0] op;
      int n, sk, ck;
      op = ($urandom % 8 == 0) ? bads[$urandom % 5] : defs[$urandom % 11];
      n = seq_len(op);
      sk = ($urandom % 6 == 0) ? int'($urandom % n) : -1;
      ck = ($urandom % 12 == 0) ? int'($urandom % n) : -1;
      run_instr({op, 27'($urandom)}, sk, ck);
    end
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
